// File: rtl/mem_burst_pkg.sv
// Shared types for the scratchpad compute-side burst reader.
//   state_t  : reader control states (IDLE / READ / DRAIN)
//   entry_t  : one output-buffer entry, a RAM word plus its end-of-burst flag
//   MB_DATA_W: word width carried by entry_t; the reader's DATA_WIDTH must match it
//   MB_MIN_FIFO_DEPTH: smallest output buffer that still works (no throughput guarantee)
package mem_burst_pkg;

  localparam int MB_DATA_W         = 32;
  localparam int MB_MIN_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [MB_DATA_W-1:0] data;
    logic                 last;
  } entry_t;

endpackage

// File: rtl/mem_burst_fifo.sv
// Output buffer for the burst reader: a small synchronous FIFO of entry_t.
// The head entry is read straight out of the register array, so out_data is
// register-driven. Caller guarantees no push when full and no pop when empty.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, din       : write one entry at the end of the cycle
//   pop             : retire the head entry at the end of the cycle
//   head            : current head entry
//   count, empty    : occupancy
module mem_burst_fifo
  import mem_burst_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer advance that also handles non-power-of-two depths.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/mem_burst_reader.sv
// Compute-side burst read engine for the dual-port scratchpad (Port B).
// Takes a (start address, length) command, issues one synchronous read per
// cycle while the output buffer has room for the word, absorbs the RAM's
// 1-cycle read latency and presents the words as a valid/ready stream with
// last-beat marking.
// Optional build macro: MEM_BURST_READER_STRIDE_EN adds cmd_stride; without
// it the address advances by 1.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   cmd_valid/ready, addr, len     : burst command (len 0 is legal)
//   cmd_stride                     : address step (stride build only)
//   mem_en, mem_we, mem_addr       : RAM Port B request (mem_we tied 0)
//   mem_rdata                      : RAM data, valid the cycle after mem_en
//   out_valid/ready, data, last    : output stream
//   busy                           : command in progress
//   done                           : one-cycle pulse when the burst is fully delivered
module mem_burst_reader
  import mem_burst_pkg::*;
#(
  parameter int DATA_WIDTH = MB_DATA_W,
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
`ifdef MEM_BURST_READER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] step;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  cmd_fire;
  logic                  issue;
  logic                  credit;
  logic [CW:0]           inflight;
  logic                  rd_vld_p1;
  logic                  rd_last_p1;
  entry_t                push_ent;
  entry_t                head_ent;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  pop;

`ifdef MEM_BURST_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;

  always_ff @(posedge clk) begin
    if (rst)           stride_q <= '0;
    else if (cmd_fire) stride_q <= cmd_stride;
  end

  assign step = stride_q;
`else
  assign step = ADDR_WIDTH'(1);
`endif

  assign cmd_ready = (state == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);

  // A read may only be issued if its word is guaranteed a buffer slot,
  // counting the read already in flight.
  assign inflight = {1'b0, fifo_count} + {{CW{1'b0}}, rd_vld_p1};
  assign credit   = (inflight < (CW + 1)'(FIFO_DEPTH));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = (cmd_len == '0) ? DRAIN : READ;
      end
      READ: begin
        if (credit) begin
          issue = 1'b1;
          if (remain_q == LEN_WIDTH'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_vld_p1 && fifo_empty) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: command latch and read issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_vld_p1  <= issue;
      rd_last_p1 <= issue && (remain_q == LEN_WIDTH'(1));
      if (cmd_fire) begin
        addr_q   <= cmd_addr;
        remain_q <= cmd_len;
      end else if (issue) begin
        addr_q   <= addr_q + step;
        remain_q <= remain_q - LEN_WIDTH'(1);
      end
    end
  end

  assign mem_en   = issue;
  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;

  // Stage p1: RAM data returns and is captured into the output buffer
  assign push_ent = '{data: mem_rdata, last: rd_last_p1};
  assign pop      = ~fifo_empty & out_ready;

  mem_burst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld_p1),
    .din   (push_ent),
    .pop   (pop),
    .head  (head_ent),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = head_ent.data;
  assign out_last  = head_ent.last;

endmodule
